// File: rtl/stosa_vectorial_top.sv
// Time-multiplexed stochastic annealing core for an antiferromagnetic ring of phase-encoded spins.
// Optional annealing noise (LFSR, temperature, sweep counter) is built only when STOSA_ANNEAL_NOISE_EN is defined.
module stosa_vectorial_top #(
    parameter int NSPIN           = 50,
    parameter int GAIN            = 32,
    parameter int SWEEPS_PER_STEP = 16
) (
    input  logic       clk_port,
    input  logic       reset_port,
    input  logic [7:0] PHASE_input_port,
    output logic [7:0] CTRL_port,
    output logic       clk_SPIN_port,
    output logic       clk_ADC_port
);

    // state   | meaning
    // S_START | out of reset, first slot not yet begun (counts as p=0)
    // S_P0    | ADC strobe high, phase sampled on exit
    // S_P1    | local field evaluated, CTRL registered on exit
    // S_P2    | CTRL valid, SPIN strobe raised on exit
    // S_P3    | SPIN strobe high, spin index advances on exit
    typedef enum logic [2:0] {
        S_START,
        S_P0,
        S_P1,
        S_P2,
        S_P3
    } slot_state_t;

    localparam int IW = (NSPIN > 2) ? $clog2(NSPIN) : 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSPIN - 1);
    // A misconfigured instance never leaves S_START rather than running a broken ring.
    localparam bit CFG_OK = (NSPIN >= 3) && (SWEEPS_PER_STEP >= 1);

    slot_state_t     state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_lo;
    logic [IW-1:0]   idx_hi;
    logic [NSPIN-1:0] spin_neg;
    logic            wrap;
    int              field;
    int              noise;
    int              v_raw;
    logic [7:0]      ctrl_next;

`ifdef STOSA_ANNEAL_NOISE_EN
    localparam int SW = (SWEEPS_PER_STEP > 1) ? $clog2(SWEEPS_PER_STEP) : 1;
    logic [15:0]       lfsr;
    logic [3:0]        temp;
    logic [SW-1:0]     sweep_left;
    logic signed [7:0] noise8;
    logic              lfsr_fb;
`endif

    always_comb begin
        idx_lo = (idx == '0) ? LAST_IDX : idx - 1'b1;
        idx_hi = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        wrap   = (idx == LAST_IDX);

        field = 0;
        if (spin_neg[idx_lo] && spin_neg[idx_hi]) begin
            field = 2;
        end else if (!spin_neg[idx_lo] && !spin_neg[idx_hi]) begin
            field = -2;
        end

`ifdef STOSA_ANNEAL_NOISE_EN
        lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        noise8  = $signed(lfsr[7:0]) >>> temp;
        noise   = (temp >= 4'd8) ? 0 : int'(noise8);
`else
        noise = 0;
`endif

        v_raw = 128 + GAIN * field + noise;
        if (v_raw < 0) begin
            ctrl_next = 8'd0;
        end else if (v_raw > 255) begin
            ctrl_next = 8'd255;
        end else begin
            ctrl_next = v_raw[7:0];
        end
    end

    always_ff @(posedge clk_port) begin
        if (reset_port) begin
            state         <= S_START;
            idx           <= '0;
            spin_neg      <= '0;
            CTRL_port     <= 8'd128;
            clk_SPIN_port <= 1'b0;
            clk_ADC_port  <= 1'b0;
`ifdef STOSA_ANNEAL_NOISE_EN
            lfsr          <= 16'hACE1;
            temp          <= 4'd0;
            sweep_left    <= SW'(SWEEPS_PER_STEP - 1);
`endif
        end else begin
            case (state)
                S_START: begin
                    if (CFG_OK) begin
                        state        <= S_P0;
                        clk_ADC_port <= 1'b1;
                    end
                end
                S_P0: begin
                    clk_ADC_port  <= 1'b0;
                    spin_neg[idx] <= (PHASE_input_port >= 8'd128);
                    state         <= S_P1;
                end
                S_P1: begin
                    CTRL_port <= ctrl_next;
`ifdef STOSA_ANNEAL_NOISE_EN
                    lfsr      <= {lfsr_fb, lfsr[15:1]};
`endif
                    state     <= S_P2;
                end
                S_P2: begin
                    clk_SPIN_port <= 1'b1;
                    state         <= S_P3;
                end
                S_P3: begin
                    clk_SPIN_port <= 1'b0;
                    clk_ADC_port  <= 1'b1;
                    idx           <= wrap ? '0 : idx + 1'b1;
`ifdef STOSA_ANNEAL_NOISE_EN
                    // Temperature steps once every SWEEPS_PER_STEP ring wraps.
                    if (wrap) begin
                        if (sweep_left == '0) begin
                            sweep_left <= SW'(SWEEPS_PER_STEP - 1);
                            if (temp < 4'd8) begin
                                temp <= temp + 4'd1;
                            end
                        end else begin
                            sweep_left <= sweep_left - 1'b1;
                        end
                    end
`endif
                    state         <= S_P0;
                end
                default: begin
                    state <= S_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stosa_vectorial_top.sv
// Randomized bench for stosa_vectorial_top against a slot-level arithmetic reference model.
module tb_stosa_vectorial_top;

    localparam int N     = 50;
    localparam int G0    = 32;
    localparam int G1    = 100;
    localparam int SPS0  = 16;
    localparam int SPS_A = 1;
`ifdef STOSA_ANNEAL_NOISE_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] phase = 8'd0;
    logic [7:0] ctrl0, ctrl1, ctrl2;
    logic       spin0, spin1, spin2;
    logic       adc0, adc1, adc2;

    always #5 clk = ~clk;

    stosa_vectorial_top #(.NSPIN(N), .GAIN(G0), .SWEEPS_PER_STEP(SPS0)) dut (
        .clk_port(clk), .reset_port(reset), .PHASE_input_port(phase),
        .CTRL_port(ctrl0), .clk_SPIN_port(spin0), .clk_ADC_port(adc0));

    stosa_vectorial_top #(.NSPIN(N), .GAIN(G1), .SWEEPS_PER_STEP(SPS0)) dut_gain (
        .clk_port(clk), .reset_port(reset), .PHASE_input_port(phase),
        .CTRL_port(ctrl1), .clk_SPIN_port(spin1), .clk_ADC_port(adc1));

    stosa_vectorial_top #(.NSPIN(N), .GAIN(G0), .SWEEPS_PER_STEP(SPS_A)) dut_anneal (
        .clk_port(clk), .reset_port(reset), .PHASE_input_port(phase),
        .CTRL_port(ctrl2), .clk_SPIN_port(spin2), .clk_ADC_port(adc2));

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;

    int          m_spin[N];
    int          m_slot;
    logic [15:0] m_lfsr;
    int          m_prev[3];
    int          gain_of[3] = '{G0, G1, G0};
    int          sps_of[3]  = '{SPS0, SPS0, SPS_A};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s slot=%0d got=%0d exp=%0d", tag, m_slot, got, exp);
        end
    endtask

    function automatic int clamp_ctrl(input int gain, input int h, input int nz);
        int v;
        v = 128 + gain * h + nz;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // floor(signed low byte / 2^t), zero once fully cooled
    function automatic int noise_of(input logic [15:0] l, input int t);
        int b, d;
        if (t >= 8) return 0;
        b = int'(l[7:0]);
        if (b >= 128) b = b - 256;
        d = 1 << t;
        if (b >= 0) return b / d;
        return -((-b + d - 1) / d);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic int gen_phase(input int mode, input int i);
        case (mode)
            0:       return 0;
            1:       return (i % 2 == 1) ? 200 : 0;
            2:       return int'($urandom_range(0, 255));
            default: return (i % 2 == 1) ? int'($urandom_range(128, 255)) : int'($urandom_range(0, 127));
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_spin[k] = 1;
        m_slot = 0;
        m_lfsr = 16'hACE1;
        for (int k = 0; k < 3; k++) m_prev[k] = 128;
    endtask

    task automatic check_outputs(input int e_adc, input int e_spin, input int e0, input int e1, input int e2);
        check("adc0", int'(adc0), e_adc);
        check("spin0", int'(spin0), e_spin);
        check("adc_gain", int'(adc1), e_adc);
        check("spin_anneal", int'(spin2), e_spin);
        check("ctrl0", int'(ctrl0), e0);
        check("ctrl_gain", int'(ctrl1), e1);
        check("ctrl_anneal", int'(ctrl2), e2);
        if (spin0) strobe_cnt++;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_outputs(0, 0, 128, 128, 128);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_slot(input int mode, input bit abort);
        int i, sw, ph, h, t, nz;
        int exp_c[3];
        i  = m_slot % N;
        sw = m_slot / N;
        ph = gen_phase(mode, i);
        phase = ph[7:0];
        m_spin[i] = (ph < 128) ? 1 : -1;
        h = -(m_spin[(i + N - 1) % N] + m_spin[(i + 1) % N]);
        for (int k = 0; k < 3; k++) begin
            t = sw / sps_of[k];
            if (t > 8) t = 8;
            nz = NOISE_ON ? noise_of(m_lfsr, t) : 0;
            exp_c[k] = clamp_ctrl(gain_of[k], h, nz);
        end
        m_lfsr = lfsr_next(m_lfsr);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            if (p < 2) check_outputs(p == 0, 0, m_prev[0], m_prev[1], m_prev[2]);
            else       check_outputs(0, p == 3, exp_c[0], exp_c[1], exp_c[2]);
            if (abort && p == 2) begin
                apply_reset(1);
                return;
            end
        end
        for (int k = 0; k < 3; k++) m_prev[k] = exp_c[k];
        m_slot++;
    endtask

    task automatic run_slots(input int n, input int mode);
        for (int s = 0; s < n; s++) run_slot(mode, 1'b0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset(3);

        strobe_cnt = 0;
        run_slots(N, 0);
        check("spin_strobes_per_sweep", strobe_cnt, N);
        run_slots(N, 0);

        apply_reset(2);
        run_slots(3 * N, 1);

        apply_reset(2);
        run_slots(2 * N, 2);
        run_slots(2 * N, 3);

        apply_reset(1);
        run_slots(7, 0);
        run_slot(0, 1'b1);
        run_slots(N, 0);

        apply_reset(2);
        run_slots(10 * N, 0);
        apply_reset(2);
        run_slots(2 * N, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
